// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC sequencing, IF/ID pipeline register and
// detection of the branch-to-self idiom (B +0) that parks fetch.
//
// state | meaning
// BOOT  | first cycle after reset; pc held at 0, IF/ID not loaded
// RUN   | sequential fetch; redirect > stall > normal load
// HALT  | parked on B +0; IF/ID bubbles until a redirect arrives
module instr_fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [15:0] rom_address,
  input  logic [31:0] rom_data,
  output logic [63:0] pc,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] BRANCH_SELF = 32'h1400_0000;

  state_t      state_q;
  state_t      state_d;
  // pc is kept as a word index so the two low bits are zero by construction
  logic [61:0] pc_word_q;
  logic [61:0] pc_word_d;
  logic [63:0] if_pc_q;
  logic [63:0] if_pc_d;
  logic [31:0] if_instr_q;
  logic [31:0] if_instr_d;
  logic        if_valid_q;
  logic        if_valid_d;
  logic [31:0] fetch_cnt_q;
  logic        load;
  logic        bubble;
  logic [61:0] redirect_word;
  logic [61:0] seq_word;
  logic        unused_redirect_lsbs;

  assign redirect_word        = redirect_pc[63:2];
  assign seq_word             = pc_word_q + 62'd1;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_word_d = pc_word_q;
    load      = 1'b0;
    bubble    = 1'b0;
    case (state_q)
      BOOT: begin
        pc_word_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        if (redirect) begin
          pc_word_d = redirect_word;
          bubble    = 1'b1;
        end else if (stall) begin
          pc_word_d = pc_word_q;
        end else if (flush) begin
          // flush only kills the IF/ID load; the PC still advances
          pc_word_d = seq_word;
        end else begin
          load = 1'b1;
          if (rom_data == BRANCH_SELF) begin
            state_d = HALT;
          end else begin
            pc_word_d = seq_word;
          end
        end
      end
      HALT: begin
        bubble = 1'b1;
        if (redirect) begin
          pc_word_d = redirect_word;
          state_d   = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    if (load) begin
      if_pc_d    = {pc_word_q, 2'b00};
      if_instr_d = rom_data;
      if_valid_d = 1'b1;
    end
    // flush overrides a stall hold, but only for the IF/ID register
    if (bubble || flush) begin
      if_instr_d = '0;
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_word_q  <= '0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
    end else begin
      pc_word_q  <= pc_word_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
    end else if (load) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign pc          = {pc_word_q, 2'b00};
  assign rom_address = pc_word_q[15:0];
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign if_valid    = if_valid_q;
  assign halted      = (state_q == HALT);
  assign fetch_count = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random stall/flush/redirect
// traffic, all compared against a behavioural fetch model.
module tb_instr_fetch_unit;

  localparam logic [31:0] B_SELF   = 32'h1400_0000;
  localparam logic [31:0] DEF_WORD = 32'hD61F_03E0;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [15:0] rom_address;
  logic [31:0] rom_data;
  logic [63:0] pc;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] rom [256];
  int          rom_gen;

  int checks;
  int failures;

  // reference model state
  logic [63:0] m_pc;
  logic [63:0] m_if_pc;
  logic [31:0] m_if_instr;
  logic        m_if_valid;
  logic        m_halted;
  logic        m_boot;
  logic [31:0] m_count;

  instr_fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .pc          (pc),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_valid    (if_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    if (a < 16'd256) return rom[a[7:0]];
    return DEF_WORD;
  endfunction

  always @(rom_address or rom_gen) rom_data = rom_word(rom_address);

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("rom_address", 64'(rom_address), 64'(m_pc[17:2]));
    chk("if_pc", if_pc, m_if_pc);
    chk("if_instr", 64'(if_instr), 64'(m_if_instr));
    chk("if_valid", 64'(if_valid), 64'(m_if_valid));
    chk("halted", 64'(halted), 64'(m_halted));
    chk("fetch_count", 64'(fetch_count), 64'(m_count));
  endtask

  task automatic model_reset();
    m_pc = '0; m_if_pc = '0; m_if_instr = '0; m_if_valid = 1'b0;
    m_halted = 1'b0; m_boot = 1'b1; m_count = '0;
  endtask

  // One clock edge of the fetch rules, written from the behavioural description.
  task automatic model_step(input logic st, input logic fl, input logic rd,
                            input logic [63:0] rpc);
    logic [31:0] w;
    logic        kill;
    w = rom_word(m_pc[17:2]);
    kill = fl;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halted) begin
      kill = 1'b1;
      if (rd) begin
        m_pc = rpc & ~64'd3;
        m_halted = 1'b0;
      end
    end else if (rd) begin
      m_pc = rpc & ~64'd3;
      kill = 1'b1;
    end else if (st) begin
      // everything held
    end else if (fl) begin
      m_pc = m_pc + 64'd4;
    end else begin
      m_if_pc = m_pc;
      m_if_instr = w;
      m_if_valid = 1'b1;
      m_count = m_count + 32'd1;
      if (w == B_SELF) m_halted = 1'b1;
      else m_pc = m_pc + 64'd4;
    end
    if (kill) begin
      m_if_valid = 1'b0;
      m_if_instr = '0;
    end
  endtask

  task automatic step(input logic st, input logic fl, input logic rd, input logic [63:0] rpc);
    stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
    model_step(st, fl, rd, rpc);
    @(posedge clock);
    #1;
    check_all();
  endtask

  logic [31:0] held_instr;
  logic [31:0] cnt_before;

  initial begin
    checks = 0; failures = 0; rom_gen = 0;
    for (int i = 0; i < 256; i++) begin
      rom[i] = $urandom;
      if (rom[i] == B_SELF) rom[i] = rom[i] ^ 32'h1;
      if (i >= 200) rom[i] = DEF_WORD;
    end
    rom[0] = 32'hD280_0054;
    rom[16] = B_SELF;
    rom_gen = 1;

    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
    model_reset();
    #1;
    check_all();
    #1 reset = 1'b0;

    // reset release into the pixel-test program
    step(0, 0, 0, 64'd0);
    chk("boot_if_valid", 64'(if_valid), 64'd0);
    step(0, 0, 0, 64'd0);
    chk("c2_if_instr", 64'(if_instr), 64'hD280_0054);
    chk("c2_if_pc", if_pc, 64'd0);
    step(0, 0, 0, 64'd0);
    chk("c3_if_pc", if_pc, 64'd4);
    chk("c3_rom_address", 64'(rom_address), 64'd2);

    // advance to pc=0x10, then hold it with stall
    step(0, 0, 0, 64'd0);
    step(0, 0, 0, 64'd0);
    chk("pre_stall_pc", pc, 64'h10);
    held_instr = if_instr;
    cnt_before = fetch_count;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 64'd0);
      chk("stall_pc", pc, 64'h10);
      chk("stall_instr", 64'(if_instr), 64'(held_instr));
    end
    step(0, 0, 0, 64'd0);
    chk("unstall_if_pc", if_pc, 64'h10);
    chk("unstall_count", 64'(fetch_count), 64'(cnt_before + 32'd1));

    // redirect wins over stall, low bits cleared
    step(1, 0, 1, 64'h1B);
    chk("redir_pc", pc, 64'h18);
    chk("redir_valid", 64'(if_valid), 64'd0);
    step(0, 0, 0, 64'd0);
    chk("redir_if_pc", if_pc, 64'h18);

    // branch-to-self park and release
    step(0, 0, 1, 64'h40);
    step(0, 0, 0, 64'd0);
    chk("halt_instr", 64'(if_instr), 64'(B_SELF));
    chk("halt_valid_once", 64'(if_valid), 64'd1);
    chk("halt_flag", 64'(halted), 64'd1);
    step(1, 0, 0, 64'd0);
    chk("halt_pc", pc, 64'h40);
    chk("halt_bubble", 64'(if_valid), 64'd0);
    step(0, 0, 1, 64'h0);
    chk("unhalt", 64'(halted), 64'd0);

    // flush with normal, stall and redirect
    step(0, 1, 0, 64'd0);
    step(0, 0, 0, 64'd0);
    step(1, 1, 0, 64'd0);
    step(0, 1, 1, 64'h80);
    step(0, 0, 0, 64'd0);

    // rom_address and 64-bit pc wrap
    step(0, 0, 1, 64'h3FFFC);
    step(0, 0, 0, 64'd0);
    chk("romaddr_wrap", 64'(rom_address), 64'd0);
    step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    step(0, 0, 0, 64'd0);
    chk("pc_wrap", pc, 64'd0);

    // fetch counter wrap
    step(0, 0, 1, 64'h0);
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.fetch_cnt_q;
    m_count = 32'hFFFF_FFFF;
    step(0, 0, 0, 64'd0);
    chk("count_wrap", 64'(fetch_count), 64'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, 64'($urandom_range(0, 127)));
    end

    // asynchronous reset mid-operation with a redirect in flight
    step(0, 0, 1, 64'h6C);
    chk("pre_reset_pc", pc, 64'h6C);
    step(0, 0, 0, 64'd0);
    redirect = 1'b1; redirect_pc = 64'h100;
    #1 reset = 1'b1;
    model_reset();
    #1;
    check_all();
    reset = 1'b0;
    step(0, 0, 1, 64'h100);
    chk("post_reset_boot", 64'(if_valid), 64'd0);
    step(0, 0, 0, 64'd0);
    chk("post_reset_if_pc", if_pc, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
